// File: rtl/cam_pixel_packer_if.sv
// Camera-side and frame-buffer-side signal bundle for cam_pixel_packer.
// slave: the packer itself. master: whatever drives the camera stream and wr_rdy.
interface cam_pixel_packer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  vsync;
    logic                  href;
    logic                  pix_vld;
    logic [7:0]            pix_data;
    logic                  wr_rdy;
    logic                  tp_sel;
    logic                  wr_req_l;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  frame_done;
    logic                  overflow;
    logic                  short_frame;
    logic                  busy;

    modport master (
        output vsync, href, pix_vld, pix_data, wr_rdy, tp_sel,
        input  wr_req_l, wr_data, frame_done, overflow, short_frame, busy
    );

    modport slave (
        input  vsync, href, pix_vld, pix_data, wr_rdy, tp_sel,
        output wr_req_l, wr_data, frame_done, overflow, short_frame, busy
    );
endinterface

// File: rtl/cam_pixel_packer.sv
// Camera byte-stream packer: vsync/href framed bytes are packed four per word,
// buffered in a first-word-fall-through FIFO and handed to the frame buffer
// with an active-low write request. Reports frame completion, overflow and
// short frames.
// Optional build macro TEST_PATTERN_EN: with tp_sel=1 each packed byte is
// replaced by a per-frame byte counter (cleared on the vsync fall).
module cam_pixel_packer #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_WORDS = 230400
) (
    input logic                wr_clk,
    input logic                reset,
    cam_pixel_packer_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WC_W  = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {WAIT_FRAME, CAPTURE, DRAIN} state_t;

    state_t                state_reg, state_next;
    logic                  vsync_reg, vsync_prev_reg;
    logic [1:0]            byte_idx_reg, byte_idx_next;
    logic [WC_W-1:0]       word_cnt_reg, word_cnt_next;
    logic [23:0]           lanes_reg;
    logic                  push_reg, push_next;
    logic [DATA_WIDTH-1:0] push_word_reg, push_word_next;
    logic                  frame_done_reg, frame_done_next;
    logic                  short_reg, short_next;
    logic                  overflow_reg;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  wr_req_l_reg;
    logic [DATA_WIDTH-1:0] wr_data_reg;

    logic                  vsync_fall, vsync_rise, pix_take;
    logic                  fifo_full, fifo_empty, pop, push_ok, drop;
    logic [7:0]            pix_byte;

    assign vsync_fall = vsync_prev_reg & ~vsync_reg;
    assign vsync_rise = ~vsync_prev_reg & vsync_reg;
    assign pix_take   = (state_reg == CAPTURE) && bus.pix_vld && bus.href;

`ifdef TEST_PATTERN_EN
    logic [7:0] tp_cnt_reg;

    // Per-frame byte counter used as the test pattern source
    always_ff @(posedge wr_clk) begin
        if (reset)           tp_cnt_reg <= '0;
        else if (vsync_fall) tp_cnt_reg <= '0;
        else if (pix_take)   tp_cnt_reg <= tp_cnt_reg + 8'd1;
    end

    assign pix_byte = bus.tp_sel ? tp_cnt_reg : bus.pix_data;
`else
    logic unused_tp_sel;
    assign unused_tp_sel = bus.tp_sel;
    assign pix_byte      = bus.pix_data;
`endif

    // vsync synchroniser stage plus previous value for edge detection
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            vsync_reg      <= 1'b0;
            vsync_prev_reg <= 1'b0;
        end else begin
            vsync_reg      <= bus.vsync;
            vsync_prev_reg <= vsync_reg;
        end
    end

    // Lower three byte lanes of the word under assembly; byte 3 goes straight into the push word
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            always_ff @(posedge wr_clk) begin
                if (reset)
                    lanes_reg[gi*8 +: 8] <= 8'h00;
                else if (pix_take && byte_idx_reg == 2'(gi))
                    lanes_reg[gi*8 +: 8] <= pix_byte;
            end
        end
    endgenerate

    // Control state register
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state_reg      <= WAIT_FRAME;
            byte_idx_reg   <= 2'd0;
            word_cnt_reg   <= '0;
            push_reg       <= 1'b0;
            push_word_reg  <= '0;
            frame_done_reg <= 1'b0;
            short_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            byte_idx_reg   <= byte_idx_next;
            word_cnt_reg   <= word_cnt_next;
            push_reg       <= push_next;
            push_word_reg  <= push_word_next;
            frame_done_reg <= frame_done_next;
            short_reg      <= short_next;
        end
    end

    // Framing FSM: byte packing, frame length tracking and drain hand-off
    always_comb begin
        state_next      = state_reg;
        byte_idx_next   = byte_idx_reg;
        word_cnt_next   = word_cnt_reg;
        push_next       = 1'b0;
        push_word_next  = push_word_reg;
        frame_done_next = 1'b0;
        short_next      = short_reg;
        case (state_reg)
            WAIT_FRAME: begin
                if (vsync_fall) begin
                    byte_idx_next = 2'd0;
                    word_cnt_next = '0;
                    state_next    = CAPTURE;
                end
            end
            CAPTURE: begin
                if (pix_take) begin
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        push_next      = 1'b1;
                        push_word_next = {pix_byte, lanes_reg};
                        word_cnt_next  = word_cnt_reg + 1'b1;
                    end
                end
                if (pix_take && byte_idx_reg == 2'd3 &&
                    word_cnt_reg == WC_W'(FRAME_WORDS - 1)) begin
                    state_next = DRAIN;
                end else if (vsync_rise) begin
                    // Frame ended early: the partial word is simply abandoned
                    short_next    = 1'b1;
                    byte_idx_next = 2'd0;
                    state_next    = DRAIN;
                end
            end
            DRAIN: begin
                // A word may still be in the push stage when DRAIN is entered
                if (fifo_empty && !push_reg) begin
                    frame_done_next = 1'b1;
                    state_next      = WAIT_FRAME;
                end
            end
            default: state_next = WAIT_FRAME;
        endcase
    end

    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign pop        = bus.wr_rdy && !wr_req_l_reg && !fifo_empty;
    assign push_ok    = push_reg && (!fifo_full || pop);
    assign drop       = push_reg && fifo_full && !pop;

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop)
            count_next = count_reg + 1'b1;
        else if (!push_ok && pop)
            count_next = count_reg - 1'b1;
    end

    // FIFO storage write port
    always_ff @(posedge wr_clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= push_word_reg;
    end

    // FIFO pointers, count, registered request and sticky overflow
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            wr_req_l_reg <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg    <= count_next;
            wr_req_l_reg <= (count_next == '0);
            if (drop)    overflow_reg <= 1'b1;
        end
    end

    // Registered head word: bypass the push word when it becomes the new head
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            wr_data_reg <= '0;
        end else if (fifo_empty && push_ok) begin
            wr_data_reg <= push_word_reg;
        end else if (pop) begin
            if (count_reg >= CNT_W'(2))
                wr_data_reg <= mem[rd_ptr_reg + 1'b1];
            else if (push_ok)
                wr_data_reg <= push_word_reg;
        end
    end

    assign bus.wr_req_l    = wr_req_l_reg;
    assign bus.wr_data     = wr_data_reg;
    assign bus.frame_done  = frame_done_reg;
    assign bus.overflow    = overflow_reg;
    assign bus.short_frame = short_reg;
    assign bus.busy        = (state_reg != WAIT_FRAME);
endmodule
